// File: rtl/pcg_pkg.sv
// -----------------------------------------------------------------------------
// pcg_pkg
// Shared definitions for the program-counter generator (pc_gen) and its
// target-calculation sub-module (pcg_tgt_calc).
//
// Contents:
//   CPU_WIDTH       core datapath width; pc_gen's default XLEN
//   PCG_ILEN_BYTES  default sequential instruction step in bytes
//   pcg_state_e     control FSM states: BOOT, RUN, HALT, WAIT_TRAP
//   pcg_align_mask  helper that maps an instruction length to the mask of
//                   PC low bits that must be zero
//   PCG_ALIGN_MASK  alignment mask for the default instruction length
// -----------------------------------------------------------------------------
package pcg_pkg;

  // Width shared with the rest of the RV64 core.
  localparam int CPU_WIDTH = 64;

  // 4 for the base ISA; 2 when the C extension is enabled.
  localparam int PCG_ILEN_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,  // first cycle after reset, nothing presented
    RUN       = 2'd1,  // presenting fetch addresses
    HALT      = 2'd2,  // parked by ebreak/halt, waits for a trap
    WAIT_TRAP = 2'd3   // misaligned redirect seen, waits for the trap
  } pcg_state_e;

  // Bit 0 must always be zero. Bit 1 must also be zero unless compressed
  // instructions are allowed (2-byte instruction length).
  function automatic logic [1:0] pcg_align_mask(input int ilen_bytes);
    return (ilen_bytes == 2) ? 2'b01 : 2'b11;
  endfunction

  localparam logic [1:0] PCG_ALIGN_MASK = pcg_align_mask(PCG_ILEN_BYTES);

endpackage : pcg_pkg

// File: rtl/pcg_tgt_calc.sv
// -----------------------------------------------------------------------------
// pcg_tgt_calc
// Purely combinational redirect-target adder with alignment check.
//
//   JAL / branch : target = pc + imm
//   JALR         : target = (rs1 + imm) & ~1
//
// Both additions are XLEN-bit modular (carry out is discarded). The target is
// misaligned when any bit selected by the alignment mask is set.
//
// Parameters:
//   XLEN        datapath / PC width
//   ILEN_BYTES  sequential step (4, or 2 with the C extension)
//
// Ports:
//   i_jalr      1: JALR form, 0: PC-relative form
//   i_pc        PC of the redirecting instruction
//   i_rs1       rs1 operand (JALR only)
//   i_imm       sign-extended immediate
//   o_target    computed redirect target
//   o_misalign  target violates instruction alignment
// -----------------------------------------------------------------------------
module pcg_tgt_calc
  import pcg_pkg::*;
#(
  parameter int XLEN       = CPU_WIDTH,
  parameter int ILEN_BYTES = PCG_ILEN_BYTES
) (
  input  logic            i_jalr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign
);

  localparam logic [1:0] ALIGN_MASK = pcg_align_mask(ILEN_BYTES);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  // One shared adder: only the base operand differs between the two forms.
  assign w_base = i_jalr ? i_rs1 : i_pc;
  assign w_sum  = w_base + i_imm;

  // JALR architecturally clears bit 0 of its sum, so only bit 1 can make a
  // JALR target misaligned in the 4-byte case.
  assign o_target   = i_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  assign o_misalign = |(o_target[1:0] & ALIGN_MASK);

endmodule : pcg_tgt_calc

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator at the head of the IF stage of the RV64 core.
// Presents fetch addresses with a valid/ready handshake, applies prioritised
// redirects (trap > halt > branch/jump > sequential), checks redirect target
// alignment and sequences a small control FSM (BOOT, RUN, HALT, WAIT_TRAP).
//
// Optional feature (compile-time macro PCG_PERF_CNT_EN):
//   defined   : adds o_fetch_cnt (fires) and o_redir_cnt (applied redirects
//               plus traps), both 64-bit, reset to 0, saturating at all-ones
//   undefined : those ports and their registers are absent
//
// Parameters:
//   XLEN        datapath / PC width
//   RST_VEC     PC presented after reset
//   ILEN_BYTES  sequential increment (4, or 2 with the C extension)
//
// Ports:
//   i_clk, i_rst_n    clock; asynchronous active-low reset
//   i_pc_rdy          fetch accepts o_pc this cycle
//   o_pc_vld, o_pc    fetch request
//   i_redir_vld       branch/jump redirect from EX
//   i_redir_jalr      selects JALR target form
//   i_redir_pc        PC of the redirecting instruction
//   i_redir_rs1       JALR base operand
//   i_redir_imm       sign-extended immediate
//   i_trap_vld        trap / mret redirect (accepted in every state)
//   i_trap_vec        trap target
//   i_halt            ebreak / halt request
//   o_flush           one-cycle pulse: the presented fetch was squashed
//   o_misalign        one-cycle pulse: redirect target misaligned
//   o_misalign_addr   last misaligned target, held until the next one
//   o_fetch_cnt       (PCG_PERF_CNT_EN) fire count
//   o_redir_cnt       (PCG_PERF_CNT_EN) applied redirect + trap count
// -----------------------------------------------------------------------------
module pc_gen
  import pcg_pkg::*;
#(
  parameter int              XLEN       = CPU_WIDTH,
  parameter logic [XLEN-1:0] RST_VEC    = XLEN'(64'h0000_0000_8000_0000),
  parameter int              ILEN_BYTES = PCG_ILEN_BYTES
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_rdy,
  output logic            o_pc_vld,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_redir_vld,
  input  logic            i_redir_jalr,
  input  logic [XLEN-1:0] i_redir_pc,
  input  logic [XLEN-1:0] i_redir_rs1,
  input  logic [XLEN-1:0] i_redir_imm,
  input  logic            i_trap_vld,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_halt,
  output logic            o_flush,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_addr
`ifdef PCG_PERF_CNT_EN
  ,
  output logic [63:0]     o_fetch_cnt,
  output logic [63:0]     o_redir_cnt
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(ILEN_BYTES);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  pcg_state_e      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_vld;
  logic            r_flush;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_addr;

  logic [XLEN-1:0] w_target;
  logic            w_tgt_misalign;
  logic            w_fire;
  logic            w_redir_run;
  logic            w_redir_ok;

  // ---------------------------------------------------------------------------
  // Redirect target
  // ---------------------------------------------------------------------------
  pcg_tgt_calc #(
    .XLEN       (XLEN),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_tgt_calc (
    .i_jalr     (i_redir_jalr),
    .i_pc       (i_redir_pc),
    .i_rs1      (i_redir_rs1),
    .i_imm      (i_redir_imm),
    .o_target   (w_target),
    .o_misalign (w_tgt_misalign)
  );

  // A fire is a completed handshake on the presented address.
  assign w_fire = r_pc_vld & i_pc_rdy;

  // A branch/jump redirect is only acted on in RUN, and only when neither a
  // trap nor a halt outranks it in the same cycle.
  assign w_redir_run = (r_state == RUN) & i_redir_vld & ~i_trap_vld & ~i_halt;
  assign w_redir_ok  = w_redir_run & ~w_tgt_misalign;

  // ---------------------------------------------------------------------------
  // Control FSM and PC register
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses nonblocking assignments so all of them
  // sample the pre-edge values of each other; the async reset clears them
  // immediately, which also discards any redirect pending at that moment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= BOOT;
      r_pc            <= RST_VEC;
      r_pc_vld        <= 1'b0;
      r_flush         <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      // NOTE: the pulse outputs default low each cycle and are raised only by
      // the event that causes them, giving exactly one-cycle pulses.
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;

      if (i_trap_vld) begin
        // Traps win in every state, including BOOT, HALT and WAIT_TRAP.
        // A flush is only meaningful if an address was being presented.
        r_state  <= RUN;
        r_pc     <= i_trap_vec;
        r_pc_vld <= 1'b1;
        r_flush  <= r_pc_vld;
      end else begin
        case (r_state)
          BOOT: begin
            // Single quiet cycle after reset release before fetching RST_VEC.
            r_state  <= RUN;
            r_pc_vld <= 1'b1;
          end

          RUN: begin
            if (i_halt) begin
              r_state  <= HALT;
              r_pc_vld <= 1'b0;
            end else if (i_redir_vld) begin
              if (w_tgt_misalign) begin
                // Stop fetching and leave the PC where it was; the trap
                // unit is expected to follow with a trap redirect.
                r_state         <= WAIT_TRAP;
                r_pc_vld        <= 1'b0;
                r_misalign      <= 1'b1;
                r_misalign_addr <= w_target;
              end else begin
                // Redirect beats the sequential step even on a fire: the
                // fired address counts as accepted, and an unaccepted one is
                // withdrawn. Either way o_pc_vld stays high, so no bubble.
                r_pc    <= w_target;
                r_flush <= r_pc_vld;
              end
            end else if (w_fire) begin
              r_pc <= r_pc + PC_STEP;  // wraps modulo 2^XLEN
            end
          end

          HALT, WAIT_TRAP: begin
            // Only a trap (handled above) or reset leaves these states.
            r_pc_vld <= 1'b0;
          end

          default: begin
            r_state  <= BOOT;
            r_pc_vld <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_pc            = r_pc;
  assign o_pc_vld        = r_pc_vld;
  assign o_flush         = r_flush;
  assign o_misalign      = r_misalign;
  assign o_misalign_addr = r_misalign_addr;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PCG_PERF_CNT_EN
  logic [63:0] r_fetch_cnt;
  logic [63:0] r_redir_cnt;
  logic        w_redir_event;

  // Traps and applied (aligned) branch/jump redirects both count.
  assign w_redir_event = i_trap_vld | w_redir_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      // Saturate rather than wrap so a long run never reads back as small.
      if (w_fire && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + 64'd1;
      end
      if (w_redir_event && (r_redir_cnt != '1)) begin
        r_redir_cnt <= r_redir_cnt + 64'd1;
      end
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_redir_cnt = r_redir_cnt;
`endif

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Self-checking bench for pc_gen (XLEN = 64, ILEN_BYTES = 4). A behavioural
// model of the generator is advanced on every clock edge and compared against
// the DUT on every falling edge; directed vectors additionally pin absolute
// values after each step. Counter ports are checked when PCG_PERF_CNT_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam int          XLEN    = 64;
  localparam int          ILEN    = 4;
  localparam logic [63:0] RST_VEC = 64'h0000_0000_8000_0000;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_rdy;
  logic        pc_vld;
  logic [63:0] pc;
  logic        redir_vld;
  logic        redir_jalr;
  logic [63:0] redir_pc;
  logic [63:0] redir_rs1;
  logic [63:0] redir_imm;
  logic        trap_vld;
  logic [63:0] trap_vec;
  logic        halt;
  logic        flush;
  logic        misalign;
  logic [63:0] misalign_addr;
`ifdef PCG_PERF_CNT_EN
  logic [63:0] fetch_cnt;
  logic [63:0] redir_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN       (XLEN),
    .RST_VEC    (RST_VEC),
    .ILEN_BYTES (ILEN)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc_rdy        (pc_rdy),
    .o_pc_vld        (pc_vld),
    .o_pc            (pc),
    .i_redir_vld     (redir_vld),
    .i_redir_jalr    (redir_jalr),
    .i_redir_pc      (redir_pc),
    .i_redir_rs1     (redir_rs1),
    .i_redir_imm     (redir_imm),
    .i_trap_vld      (trap_vld),
    .i_trap_vec      (trap_vec),
    .i_halt          (halt),
    .o_flush         (flush),
    .o_misalign      (misalign),
    .o_misalign_addr (misalign_addr)
`ifdef PCG_PERF_CNT_EN
    ,
    .o_fetch_cnt     (fetch_cnt),
    .o_redir_cnt     (redir_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] pc;
    logic        vld;
    int          mode;
    logic        flush;
    logic        mis;
    logic [63:0] mis_addr;
    logic [63:0] fcnt;
    logic [63:0] rcnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc       = RST_VEC;
    r.vld      = 1'b0;
    r.mode     = M_BOOT;
    r.flush    = 1'b0;
    r.mis      = 1'b0;
    r.mis_addr = 64'd0;
    r.fcnt     = 64'd0;
    r.rcnt     = 64'd0;
    return r;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == {64{1'b1}}) ? v : v + 64'd1;
  endfunction

  function automatic model_t model_step(
    input model_t      c,
    input logic        rdy,
    input logic        rv,
    input logic        jalr,
    input logic [63:0] rpc,
    input logic [63:0] rs1,
    input logic [63:0] imm,
    input logic        tv,
    input logic [63:0] tvec,
    input logic        hlt
  );
    model_t      n;
    logic [63:0] t;
    logic        bad;
    n       = c;
    n.flush = 1'b0;
    n.mis   = 1'b0;
    if (c.vld && rdy) n.fcnt = sat_inc(c.fcnt);
    if (jalr) begin
      t = rs1 + imm;
      t = t - (t % 64'd2);
    end else begin
      t = rpc + imm;
    end
    bad = (t % 64'(ILEN)) != 64'd0;
    if (tv) begin
      n.pc    = tvec;
      n.vld   = 1'b1;
      n.mode  = M_RUN;
      n.flush = c.vld;
      n.rcnt  = sat_inc(c.rcnt);
    end else if (c.mode == M_BOOT) begin
      n.mode = M_RUN;
      n.vld  = 1'b1;
    end else if (c.mode == M_RUN) begin
      if (hlt) begin
        n.mode = M_HALT;
        n.vld  = 1'b0;
      end else if (rv && bad) begin
        n.mis      = 1'b1;
        n.mis_addr = t;
        n.mode     = M_WAIT;
        n.vld      = 1'b0;
      end else if (rv) begin
        n.pc    = t;
        n.flush = c.vld;
        n.rcnt  = sat_inc(c.rcnt);
      end else if (c.vld && rdy) begin
        n.pc = c.pc + 64'(ILEN);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, pc_rdy, redir_vld, redir_jalr, redir_pc, redir_rs1,
                         redir_imm, trap_vld, trap_vec, halt);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model pc_vld", {63'd0, pc_vld}, {63'd0, m.vld});
      check("model pc", pc, m.pc);
      check("model flush", {63'd0, flush}, {63'd0, m.flush});
      check("model misalign", {63'd0, misalign}, {63'd0, m.mis});
      check("model misalign_addr", misalign_addr, m.mis_addr);
`ifdef PCG_PERF_CNT_EN
      check("model fetch_cnt", fetch_cnt, m.fcnt);
      check("model redir_cnt", redir_cnt, m.rcnt);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redir_vld  = 1'b0;
    redir_jalr = 1'b0;
    redir_pc   = 64'd0;
    redir_rs1  = 64'd0;
    redir_imm  = 64'd0;
    trap_vld   = 1'b0;
    trap_vec   = 64'd0;
    halt       = 1'b0;
  endtask

  task automatic do_trap(input logic [63:0] vec);
    trap_vld = 1'b1;
    trap_vec = vec;
    tick();
    trap_vld = 1'b0;
  endtask

  task automatic branch(input logic jalr, input logic [63:0] bpc,
                        input logic [63:0] rs1, input logic [63:0] imm);
    redir_vld  = 1'b1;
    redir_jalr = jalr;
    redir_pc   = bpc;
    redir_rs1  = rs1;
    redir_imm  = imm;
    tick();
    redir_vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n  = 1'b0;
    pc_rdy = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("reset pc", pc, RST_VEC);
    check("reset vld", {63'd0, pc_vld}, 64'd0);
    check("reset misalign_addr", misalign_addr, 64'd0);
    cmp_en = 1'b1;

    // Reset release with fetch always ready.
    rst_n  = 1'b1;
    pc_rdy = 1'b1;
    check("boot vld", {63'd0, pc_vld}, 64'd0);
    tick();
    check("run pc0", pc, 64'h8000_0000);
    check("run vld", {63'd0, pc_vld}, 64'd1);
    tick();
    check("run pc1", pc, 64'h8000_0004);
    tick();
    check("run pc2", pc, 64'h8000_0008);
    tick();
    tick();
    check("run pc4", pc, 64'h8000_0010);

    // Back-pressure: nothing moves.
    pc_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall pc", pc, 64'h8000_0010);
      check("stall vld", {63'd0, pc_vld}, 64'd1);
    end

    // Branch withdrawing an unaccepted address.
    branch(1'b0, 64'h8000_0020, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    check("branch pc", pc, 64'h8000_0018);
    check("branch flush", {63'd0, flush}, 64'd1);
    check("branch vld", {63'd0, pc_vld}, 64'd1);
    tick();
    check("branch flush pulse", {63'd0, flush}, 64'd0);

    // Misaligned JALR: park in WAIT_TRAP.
    branch(1'b1, 64'd0, 64'h8000_1003, 64'd0);
    check("jalr misalign", {63'd0, misalign}, 64'd1);
    check("jalr misalign_addr", misalign_addr, 64'h8000_1002);
    check("jalr vld", {63'd0, pc_vld}, 64'd0);
    check("jalr pc held", pc, 64'h8000_0018);
    tick();
    check("misalign pulse", {63'd0, misalign}, 64'd0);
    check("misalign_addr held", misalign_addr, 64'h8000_1002);
    // Redirect and halt are ignored while waiting for the trap.
    halt = 1'b1;
    branch(1'b0, 64'h8000_0000, 64'd0, 64'd4);
    halt = 1'b0;
    check("wait ignores redir", {63'd0, pc_vld}, 64'd0);
    check("wait pc", pc, 64'h8000_0018);
    do_trap(64'h8000_0100);
    check("trap pc", pc, 64'h8000_0100);
    check("trap vld", {63'd0, pc_vld}, 64'd1);
    check("trap no flush", {63'd0, flush}, 64'd0);

    // Redirect coincident with a fire: target replaces the increment.
    pc_rdy = 1'b1;
    branch(1'b0, 64'h8000_0100, 64'd0, 64'h40);
    check("fire+redir pc", pc, 64'h8000_0140);
    check("fire+redir flush", {63'd0, flush}, 64'd1);
    pc_rdy = 1'b0;

    // Trap and redirect together: trap wins.
    redir_vld = 1'b1;
    redir_pc  = 64'h8000_0000;
    redir_imm = 64'h8;
    do_trap(64'h8000_0200);
    redir_vld = 1'b0;
    check("trap beats redir", pc, 64'h8000_0200);

    // PC wrap, then halt.
    do_trap(64'hFFFF_FFFF_FFFF_FFFC);
    check("near top pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    pc_rdy = 1'b1;
    tick();
    check("wrap pc", pc, 64'd0);
    pc_rdy = 1'b0;
    halt   = 1'b1;
    tick();
    halt   = 1'b0;
    check("halt vld", {63'd0, pc_vld}, 64'd0);
    check("halt pc", pc, 64'd0);
    tick();
    check("halt stays", {63'd0, pc_vld}, 64'd0);
    do_trap(64'h8000_0000);
    check("halt exit", {63'd0, pc_vld}, 64'd1);

    // Halt outranks a same-cycle redirect.
    halt = 1'b1;
    branch(1'b0, 64'h8000_0000, 64'd0, 64'h10);
    halt = 1'b0;
    check("halt beats redir vld", {63'd0, pc_vld}, 64'd0);
    check("halt beats redir pc", pc, 64'h8000_0000);
    do_trap(64'h8000_0400);

    // Odd and half-word-aligned targets are both rejected for 4-byte ILEN.
    branch(1'b0, 64'h8000_0000, 64'd0, 64'd1);
    check("odd target", misalign_addr, 64'h8000_0001);
    do_trap(64'h8000_0400);
    branch(1'b0, 64'h8000_0000, 64'd0, 64'd2);
    check("halfword target", {63'd0, misalign}, 64'd1);
    do_trap(64'h8000_0400);
    // JALR clearing bit 0 yields an aligned target.
    branch(1'b1, 64'd0, 64'h8000_0501, 64'hFFFF_FFFF_FFFF_FFFF);
    check("jalr aligned pc", pc, 64'h8000_0500);

    // Reset during a redirect: immediate return to reset state.
    pc_rdy    = 1'b1;
    redir_vld = 1'b1;
    redir_pc  = 64'h8000_0000;
    redir_imm = 64'h100;
    rst_n     = 1'b0;
    #1;
    check("midreset pc", pc, RST_VEC);
    check("midreset vld", {63'd0, pc_vld}, 64'd0);
    check("midreset misalign_addr", misalign_addr, 64'd0);
    tick();
    redir_vld = 1'b0;
    rst_n     = 1'b1;
    check("reboot vld", {63'd0, pc_vld}, 64'd0);
    tick();
    check("reboot pc", pc, RST_VEC);
    tick();
    check("reboot step", pc, RST_VEC + 64'd4);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator for the RV64 core.
- Replaces the fixed-step PC register with four additions:
  - valid/ready handshake toward instruction fetch;
  - prioritised redirect sources (trap, branch/jump);
  - target-alignment checking;
  - a small control FSM (boot, run, halt, wait-for-trap).
- Sits at the head of the IF stage; its redirect inputs come from EX and the trap unit.

Parameters:
- XLEN, 64, datapath and PC width in bits.
- RST_VEC, 64'h0000_0000_8000_0000, PC value presented after reset.
- ILEN_BYTES, 4, sequential increment; legal values are 4, or 2 when the C extension is used.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pc_rdy  in  1  fetch accepts o_pc this cycle
- o_pc_vld  out  1  o_pc is a valid fetch address
- o_pc  out  XLEN  fetch address
- i_redir_vld  in  1  branch/jump resolved in EX and must redirect
- i_redir_jalr  in  1  1: target = (rs1+imm) & ~1; 0: target = pc+imm
- i_redir_pc  in  XLEN  PC of the redirecting instruction
- i_redir_rs1  in  XLEN  rs1 operand for JALR
- i_redir_imm  in  XLEN  sign-extended immediate
- i_trap_vld  in  1  trap/mret redirect
- i_trap_vec  in  XLEN  trap target; must be aligned
- i_halt  in  1  ebreak/halt request
- o_flush  out  1  pulse: the in-flight fetch is squashed
- o_misalign  out  1  pulse: redirect target misaligned
- o_misalign_addr  out  XLEN  offending target; held until the next misalign event

Behaviour:
- Reset (asynchronous):
  - state = BOOT, o_pc = RST_VEC, o_pc_vld = 0;
  - o_flush = 0, o_misalign = 0, o_misalign_addr = 0.
- BOOT: lasts exactly one cycle after reset deasserts, with o_pc_vld = 0; then goes to RUN.
- RUN:
  - o_pc_vld = 1.
  - Fire = o_pc_vld & i_pc_rdy. On fire with no redirect: o_pc <= o_pc + ILEN_BYTES, modulo 2^XLEN (wraps silently).
  - With no fire and no redirect, o_pc and o_pc_vld hold stable.
- Redirect priority: trap > halt > redirect > sequential.
- i_trap_vld, in any state:
  - o_pc <= i_trap_vec; state <= RUN;
  - o_flush pulses when o_pc_vld was 1 that cycle.
- i_halt, in RUN:
  - state <= HALT, o_pc_vld <= 0, o_pc holds.
  - HALT exits only on i_trap_vld or reset.
- i_redir_vld, in RUN:
  - Target is computed combinationally as XLEN-bit modular add.
  - Target is aligned (bit1 = 0 when ILEN_BYTES = 4; bit0 is always 0):
    - o_pc <= target next cycle, o_pc_vld stays 1;
    - o_flush = 1 for one cycle if o_pc_vld was 1.
  - Target is misaligned:
    - o_misalign = 1 and o_misalign_addr = target for one cycle;
    - state <= WAIT_TRAP, o_pc_vld <= 0, o_pc holds.
- Redirect withdrawal: a redirect may withdraw a presented-but-unaccepted o_pc. This is flush semantics, not a handshake violation; o_flush marks it.
- Redirect coincident with fire: the fired PC counts as accepted and o_pc takes the target; sequential increment is suppressed.
- WAIT_TRAP: o_pc_vld = 0; i_redir_vld and i_halt are ignored; only i_trap_vld exits.
- Latency: redirect-to-new-o_pc is 1 cycle; no bubble is inserted on an aligned redirect.
- Reset asserted mid-operation: everything returns to its reset values immediately; no pending redirect survives.

Optional Feature:
- Macro: PCG_PERF_CNT_EN.
- Defined:
  - adds output o_fetch_cnt (64-bit): count of fires;
  - adds output o_redir_cnt (64-bit): count of applied redirects plus traps;
  - both counters reset to 0 and saturate at all-ones.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package (pcg_pkg):
  - typedef enum logic [1:0] pcg_state_e {BOOT, RUN, HALT, WAIT_TRAP};
  - localparam PCG_ALIGN_MASK, derived from ILEN_BYTES;
  - the XLEN default shared with the existing CPU_WIDTH constant.
- Sub-module pcg_tgt_calc: purely combinational target adder with alignment check; produces target and misalign.
- FSM, PC register and counters live in pc_gen.

Test Plan:
- Reset release, i_pc_rdy = 1 held for 4 cycles:
  - o_pc_vld = 0 in cycle 1;
  - o_pc then steps 0x80000000, 0x80000004, 0x80000008.
- i_pc_rdy = 0 for 3 cycles at o_pc = 0x80000010: o_pc and o_pc_vld hold unchanged; no increment.
- Branch redirect, i_redir_pc = 0x80000020, i_redir_imm = -8, while i_pc_rdy = 0:
  - o_flush = 1 for one cycle;
  - next o_pc = 0x80000018 with o_pc_vld = 1.
- JALR redirect, rs1 = 0x80001003, imm = 0:
  - target = 0x80001002 is misaligned, so o_misalign = 1 and o_misalign_addr = 0x80001002;
  - o_pc_vld goes 0 and stays 0;
  - i_trap_vec = 0x80000100 with i_trap_vld then gives o_pc = 0x80000100, o_pc_vld = 1.
- i_redir_vld and i_trap_vld asserted in the same cycle: o_pc = i_trap_vec (trap wins).
- o_pc = 0xFFFF_FFFF_FFFF_FFFC with a fire: o_pc wraps to 0; then i_halt gives o_pc_vld = 0 and o_pc held.
